// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the sequencer and its instruction/data memories.
interface cpu_sequencer_if;
  logic       Start;
  logic [2:0] Opcode;
  logic [4:0] Address;
  logic       Zero;
  logic [4:0] Program_counter;
  logic       Mem_rd;
  logic       Mem_wr;
  logic       Acc_load;
  logic [1:0] Alu_sel;
  logic       Halted;
  logic [7:0] Retired;

  modport master (
    input  Start, Opcode, Address, Zero,
    output Program_counter, Mem_rd, Mem_wr, Acc_load, Alu_sel, Halted, Retired
  );

  modport slave (
    output Start, Opcode, Address, Zero,
    input  Program_counter, Mem_rd, Mem_wr, Acc_load, Alu_sel, Halted, Retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle accumulator CPU control sequencer: IDLE/FETCH/DECODE/EXEC/WB/HALT.
// Strobes decode combinationally from state + IR so an async reset drops them at once.
module cpu_sequencer #(
  parameter logic [4:0] RESET_PC   = 5'd0,
  parameter bit         AUTO_START = 1'b0
) (
  input  logic           Clk,
  input  logic           Reset,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t     r_state, w_next;
  logic [4:0] r_pc, w_pc_next;
  logic [2:0] r_ir_op;
  logic [4:0] r_ir_addr;
  logic [7:0] r_retired;
  logic       w_ir_ld, w_retire, w_acc_op;
  logic       w_mem_rd, w_mem_wr, w_acc_load, w_halted;
  logic [1:0] w_alu_sel, w_alu_code;
  logic       w_ir_addr_unused;

  // Operand address is held for the external data-memory port, not used here.
  assign w_ir_addr_unused = ^r_ir_addr;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc      <= RESET_PC;
      r_ir_op   <= 3'b000;
      r_ir_addr <= 5'd0;
      r_retired <= 8'd0;
    end else begin
      r_pc <= w_pc_next;
      if (w_ir_ld) begin
        r_ir_op   <= bus.Opcode;
        r_ir_addr <= bus.Address;
      end
      if (w_retire && (r_retired != 8'hFF)) r_retired <= r_retired + 8'd1;
    end
  end

  always_comb begin
    w_acc_op   = 1'b0;
    w_alu_code = 2'b00;
    case (r_ir_op)
      OP_ADD: begin w_acc_op = 1'b1; w_alu_code = 2'b00; end
      OP_AND: begin w_acc_op = 1'b1; w_alu_code = 2'b01; end
      OP_XOR: begin w_acc_op = 1'b1; w_alu_code = 2'b10; end
      OP_LDA: begin w_acc_op = 1'b1; w_alu_code = 2'b11; end
      default: ;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_pc_next  = r_pc;
    w_ir_ld    = 1'b0;
    w_retire   = 1'b0;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_acc_load = 1'b0;
    w_alu_sel  = 2'b00;
    w_halted   = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.Start || AUTO_START) w_next = S_FETCH;
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        // Branch decisions use the live opcode; later strobes use the IR copy.
        w_ir_ld = 1'b1;
        case (bus.Opcode)
          OP_HLT: begin w_next = S_HALT; w_retire = 1'b1; end
          OP_JMP: begin w_next = S_FETCH; w_retire = 1'b1; w_pc_next = bus.Address; end
          OP_SKZ: begin
            w_next    = S_FETCH;
            w_retire  = 1'b1;
            w_pc_next = r_pc + (bus.Zero ? 5'd2 : 5'd1);
          end
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        w_mem_rd = w_acc_op;
        w_mem_wr = (r_ir_op == OP_STO);
        w_next   = S_WB;
      end
      S_WB: begin
        w_acc_load = w_acc_op;
        w_alu_sel  = w_acc_op ? w_alu_code : 2'b00;
        w_pc_next  = r_pc + 5'd1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
        if (bus.Start) begin
          w_next    = S_FETCH;
          w_pc_next = r_pc + 5'd1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.Program_counter = r_pc;
  assign bus.Mem_rd          = w_mem_rd;
  assign bus.Mem_wr          = w_mem_wr;
  assign bus.Acc_load        = w_acc_load;
  assign bus.Alu_sel         = w_alu_sel;
  assign bus.Halted          = w_halted;
  assign bus.Retired         = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a registered instruction-memory model.
module tb_cpu_sequencer;

  logic Clk;
  logic Reset;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  logic [2:0] mem_op [32];
  logic [4:0] mem_ad [32];

  cpu_sequencer_if bus ();

  cpu_sequencer #(.RESET_PC(5'd0), .AUTO_START(1'b0)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    bus.Opcode  <= mem_op[bus.Program_counter];
    bus.Address <= mem_ad[bus.Program_counter];
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] prev;
    logic       wrapped;
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Zero  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem_op[i] = 3'b000;
      mem_ad[i] = 5'd0;
    end
    mem_op[0] = 3'b101; mem_ad[0] = 5'd5;   // LDA 5
    mem_op[1] = 3'b010; mem_ad[1] = 5'd6;   // ADD 6
    mem_op[2] = 3'b110; mem_ad[2] = 5'd7;   // STO 7
    mem_op[3] = 3'b000;                     // HLT
    mem_op[4] = 3'b111; mem_ad[4] = 5'd17;  // JMP 17

    #12;
    chk("rst_pc", bus.Program_counter, 0);
    chk("rst_rd", bus.Mem_rd, 0);
    chk("rst_wr", bus.Mem_wr, 0);
    chk("rst_acc", bus.Acc_load, 0);
    chk("rst_sel", bus.Alu_sel, 0);
    chk("rst_halt", bus.Halted, 0);
    chk("rst_ret", bus.Retired, 0);
    Reset = 1'b0;

    tick; tick; tick;
    chk("idle_pc", bus.Program_counter, 0);
    chk("idle_rd", bus.Mem_rd, 0);
    chk("idle_ret", bus.Retired, 0);

    // LDA / ADD / STO / HLT program
    bus.Start = 1'b1;
    tick;
    bus.Start = 1'b0;
    tick;
    chk("lda_dec_rd", bus.Mem_rd, 0);
    tick;
    chk("lda_exec_rd", bus.Mem_rd, 1);
    chk("lda_exec_pc", bus.Program_counter, 0);
    chk("lda_exec_acc", bus.Acc_load, 0);
    tick;
    chk("lda_wb_acc", bus.Acc_load, 1);
    chk("lda_wb_sel", bus.Alu_sel, 3);
    chk("lda_wb_rd", bus.Mem_rd, 0);
    tick;
    chk("add_fetch_pc", bus.Program_counter, 1);
    chk("add_fetch_ret", bus.Retired, 1);
    chk("add_fetch_acc", bus.Acc_load, 0);
    tick; tick;
    chk("add_exec_rd", bus.Mem_rd, 1);
    chk("add_exec_pc", bus.Program_counter, 1);
    tick;
    chk("add_wb_acc", bus.Acc_load, 1);
    chk("add_wb_sel", bus.Alu_sel, 0);
    tick;
    chk("sto_fetch_pc", bus.Program_counter, 2);
    chk("sto_fetch_ret", bus.Retired, 2);
    tick; tick;
    chk("sto_exec_wr", bus.Mem_wr, 1);
    chk("sto_exec_rd", bus.Mem_rd, 0);
    chk("sto_exec_pc", bus.Program_counter, 2);
    tick;
    chk("sto_wb_wr", bus.Mem_wr, 0);
    chk("sto_wb_acc", bus.Acc_load, 0);
    chk("sto_wb_sel", bus.Alu_sel, 0);
    tick; tick; tick;
    chk("hlt_halted", bus.Halted, 1);
    chk("hlt_pc", bus.Program_counter, 3);
    chk("hlt_ret", bus.Retired, 4);

    // Resume, JMP 17 -> JMP 9 -> HLT at 9
    mem_op[17] = 3'b111; mem_ad[17] = 5'd9;
    mem_op[10] = 3'b111; mem_ad[10] = 5'd30;
    mem_op[0]  = 3'b111; mem_ad[0]  = 5'd30;
    mem_op[30] = 3'b001;
    mem_op[31] = 3'b001;
    tick; tick;
    chk("halt_hold", bus.Halted, 1);
    chk("halt_hold_pc", bus.Program_counter, 3);
    bus.Start = 1'b1;
    tick;
    bus.Start = 1'b0;
    chk("resume_pc", bus.Program_counter, 4);
    chk("resume_halt", bus.Halted, 0);
    chk("resume_ret", bus.Retired, 4);
    tick;
    chk("jmp_dec_pc", bus.Program_counter, 4);
    tick;
    chk("jmp_target", bus.Program_counter, 17);
    chk("jmp_ret", bus.Retired, 5);
    tick; tick;
    chk("jmp9_pc", bus.Program_counter, 9);
    tick; tick;
    chk("halt9", bus.Halted, 1);
    chk("halt9_pc", bus.Program_counter, 9);
    chk("halt9_ret", bus.Retired, 7);
    tick; tick; tick;
    chk("halt9_hold", bus.Halted, 1);
    bus.Start = 1'b1;
    tick;
    chk("resume10_pc", bus.Program_counter, 10);
    chk("resume10_halt", bus.Halted, 0);
    tick; tick;
    bus.Start = 1'b0;
    chk("start_ignored_pc", bus.Program_counter, 30);
    chk("start_ignored_ret", bus.Retired, 8);

    // SKZ wrap cases
    bus.Zero = 1'b1;
    tick;
    tick;
    chk("skz30_z1", bus.Program_counter, 0);
    chk("skz30_ret", bus.Retired, 9);
    tick; tick;
    chk("jmp30_pc", bus.Program_counter, 30);
    tick;
    bus.Zero = 1'b0;
    tick;
    chk("skz30_z0", bus.Program_counter, 31);
    bus.Zero = 1'b1;
    tick; tick;
    bus.Zero = 1'b0;
    chk("skz31_z1", bus.Program_counter, 1);
    chk("skz31_ret", bus.Retired, 12);

    // ADD at 1, then reset in the middle of STO EXEC at 2
    tick; tick;
    chk("add1_exec_rd", bus.Mem_rd, 1);
    tick; tick;
    chk("sto2_fetch_pc", bus.Program_counter, 2);
    tick; tick;
    chk("sto2_exec_wr", bus.Mem_wr, 1);
    #3 Reset = 1'b1;
    #1;
    chk("async_wr", bus.Mem_wr, 0);
    chk("async_pc", bus.Program_counter, 0);
    chk("async_ret", bus.Retired, 0);
    chk("async_halt", bus.Halted, 0);
    mem_op[0] = 3'b101; mem_ad[0] = 5'd5;
    tick; tick;
    Reset = 1'b0;
    tick; tick;
    chk("post_rst_rd", bus.Mem_rd, 0);
    chk("post_rst_pc", bus.Program_counter, 0);
    bus.Start = 1'b1;
    tick;
    bus.Start = 1'b0;
    tick; tick;
    chk("post_rst_exec_rd", bus.Mem_rd, 1);
    chk("post_rst_exec_pc", bus.Program_counter, 0);

    // Retired saturation with an ADD/JMP loop
    Reset = 1'b1;
    tick;
    mem_op[0] = 3'b010; mem_ad[0] = 5'd0;
    mem_op[1] = 3'b111; mem_ad[1] = 5'd0;
    Reset = 1'b0;
    tick;
    bus.Start = 1'b1;
    tick;
    bus.Start = 1'b0;
    repeat (60) tick;
    chk("loop_ret20", bus.Retired, 20);
    wrapped = 1'b0;
    for (int i = 0; i < 840; i++) begin
      prev = bus.Retired;
      tick;
      if (bus.Retired < prev) wrapped = 1'b1;
    end
    chk("sat_ret", bus.Retired, 255);
    chk("sat_nowrap", wrapped, 0);
    chk("sat_halt", bus.Halted, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
